// File: rtl/maxnet_param_if.sv
// Handshake/result bundle for the MaxNet winner-take-all engine.
// The driver side owns start/din; the engine owns the registered result fields.
interface maxnet_param_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int IDXW = $clog2(N);

  logic            start;
  logic [N*W-1:0]  din;
  logic            done;
  logic [IDXW-1:0] winner;
  logic [W-1:0]    win_val;
  logic [1:0]      status;
  logic [7:0]      iters;

  modport master (output start, din, input done, winner, win_val, status, iters);
  modport slave  (input start, din, output done, winner, win_val, status, iters);
endinterface

// File: rtl/maxnet_param.sv
// MaxNet winner-take-all: one lateral-inhibition update per clock until a unique
// survivor, all-zero, stall or (with `MAXNET_TIMEOUT_EN) the iteration cap ends the run.
module maxnet_param #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int EPS_SHIFT = 2,
  parameter int MAX_ITER  = 64
) (
  input  logic           clk,
  input  logic           rst,
  maxnet_param_if.slave  bus
);
  localparam int IDXW = $clog2(N);
  localparam int SW   = W + IDXW;
  localparam int CW   = $clog2(N + 1);

`ifndef MAXNET_TIMEOUT_EN
  localparam int cap_unused = MAX_ITER;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    a   [N];
  logic [W-1:0]    nxt [N];
  logic [7:0]      iter_cnt;
  logic [SW-1:0]   sum;
  logic [CW-1:0]   nz_a, nz_nxt;
  logic [IDXW-1:0] nz_idx, max_idx, fin_idx;
  logic [W-1:0]    max_val;
  logic            stall, fin;
  logic [1:0]      fin_status;

  // Floor subtraction: a neuron is clamped at zero rather than wrapping.
  function automatic logic [W-1:0] inhibit(input logic [W-1:0] aj, input logic [SW-1:0] s);
    logic [SW-1:0] inh;
    inh = (s - SW'(aj)) >> EPS_SHIFT;
    return (SW'(aj) > inh) ? W'(SW'(aj) - inh) : '0;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    sum = '0;
    for (int j = 0; j < N; j++) sum = sum + SW'(a[j]);
  end

  always_comb begin
    nxt     = '{default: '0};
    nz_a    = '0;
    nz_nxt  = '0;
    nz_idx  = '0;
    max_idx = '0;
    max_val = '0;
    stall   = 1'b1;
    for (int j = 0; j < N; j++) begin
      nxt[j] = inhibit(a[j], sum);
      if (a[j] != '0) begin
        nz_a   = nz_a + CW'(1);
        nz_idx = IDXW'(j);
      end
      if (nxt[j] != '0) nz_nxt = nz_nxt + CW'(1);
      // Strict compare keeps the lowest index on ties.
      if (a[j] > max_val) begin
        max_val = a[j];
        max_idx = IDXW'(j);
      end
      if (nxt[j] != a[j]) stall = 1'b0;
    end
  end

  always_comb begin
    fin        = 1'b1;
    fin_status = 2'b01;
    fin_idx    = max_idx;
    if (nz_a == '0) begin
      fin_status = 2'b10;
      fin_idx    = '0;
    end else if (nz_a == CW'(1)) begin
      fin_status = 2'b00;
      fin_idx    = nz_idx;
    end
`ifdef MAXNET_TIMEOUT_EN
    else if (iter_cnt == 8'(MAX_ITER)) begin
      fin_status = 2'b11;
    end
`endif
    else if (nz_nxt == '0 || stall) begin
      fin_status = 2'b01;
    end else begin
      fin = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      iter_cnt    <= '0;
      bus.done    <= 1'b0;
      bus.winner  <= '0;
      bus.win_val <= '0;
      bus.status  <= '0;
      bus.iters   <= '0;
      for (int j = 0; j < N; j++) a[j] <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            for (int j = 0; j < N; j++) a[j] <= bus.din[j*W +: W];
            iter_cnt <= '0;
            bus.done <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (fin) begin
            state       <= DONE;
            bus.done    <= 1'b1;
            bus.status  <= fin_status;
            bus.winner  <= fin_idx;
            bus.win_val <= a[fin_idx];
            bus.iters   <= iter_cnt;
          end else begin
            for (int j = 0; j < N; j++) a[j] <= nxt[j];
            iter_cnt <= sat_inc(iter_cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_maxnet_param.sv
// Bench for maxnet_param: directed vector table, randomized runs against an
// integer MaxNet model, and start/reset control sequences.
module tb_maxnet_param;
  localparam int N = 4;
  localparam int W = 8;
  localparam int EPS_SHIFT = 2;
`ifdef MAXNET_TIMEOUT_EN
  localparam int  MAX_ITER = 2;
  localparam bit  CAP_EN   = 1'b1;
`else
  localparam int  MAX_ITER = 64;
  localparam bit  CAP_EN   = 1'b0;
`endif
  localparam int BOUND = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maxnet_param_if #(.N(N), .W(W)) bus ();

  maxnet_param #(.N(N), .W(W), .EPS_SHIFT(EPS_SHIFT), .MAX_ITER(MAX_ITER)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int winner; int val; int status; int iters; int cyc;
  } res_t;

  typedef struct {
    logic [N*W-1:0] din;
    res_t           exp;
  } vec_t;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Plain-integer MaxNet: iterate the update rule until a stop condition.
  function automatic res_t model(input logic [N*W-1:0] v);
    int a[N]; int nx[N];
    int s, nz, nzi, mx, mi, k, nnz;
    bit same;
    res_t r;
    for (int j = 0; j < N; j++) a[j] = int'(v[j*W +: W]);
    k = 0;
    r = '{0, 0, 0, 0, 0};
    for (int step = 0; step < BOUND; step++) begin
      s = 0; nz = 0; nzi = 0; mx = -1; mi = 0;
      for (int j = 0; j < N; j++) begin
        s += a[j];
        if (a[j] != 0) begin nz++; nzi = j; end
        if (a[j] > mx) begin mx = a[j]; mi = j; end
      end
      r.iters = (k > 255) ? 255 : k;
      r.cyc   = k + 1;
      if (nz == 0) begin r.winner = 0; r.val = 0; r.status = 2; return r; end
      if (nz == 1) begin r.winner = nzi; r.val = a[nzi]; r.status = 0; return r; end
      if (CAP_EN && k == MAX_ITER) begin r.winner = mi; r.val = mx; r.status = 3; return r; end
      nnz = 0; same = 1'b1;
      for (int j = 0; j < N; j++) begin
        int inh;
        inh = (s - a[j]) / (1 << EPS_SHIFT);
        nx[j] = (a[j] > inh) ? a[j] - inh : 0;
        if (nx[j] != 0) nnz++;
        if (nx[j] != a[j]) same = 1'b0;
      end
      if (nnz == 0 || same) begin r.winner = mi; r.val = mx; r.status = 1; return r; end
      a = nx;
      k++;
    end
    return r;
  endfunction

  task automatic launch(input logic [N*W-1:0] v);
    @(negedge clk);
    bus.din   = v;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(inout int cyc);
    while (!bus.done && cyc < BOUND) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_res(input string tag, input res_t e, input int cyc);
    chk({tag, "_cyc"},    cyc,               e.cyc);
    chk({tag, "_winner"}, int'(bus.winner),  e.winner);
    chk({tag, "_val"},    int'(bus.win_val), e.val);
    chk({tag, "_status"}, int'(bus.status),  e.status);
    chk({tag, "_iters"},  int'(bus.iters),   e.iters);
  endtask

  vec_t tbl[4];
  logic [N*W-1:0] v;
  int cyc;

  initial begin
    bus.start = 1'b0;
    bus.din   = '0;

`ifdef MAXNET_TIMEOUT_EN
    tbl[0] = '{{8'd40, 8'd30, 8'd20, 8'd10}, '{3, 22, 3, 2, 3}};
    tbl[1] = '{{8'd50, 8'd50, 8'd50, 8'd50}, '{0, 4, 3, 2, 3}};
`else
    tbl[0] = '{{8'd40, 8'd30, 8'd20, 8'd10}, '{3, 21, 0, 4, 5}};
    tbl[1] = '{{8'd50, 8'd50, 8'd50, 8'd50}, '{0, 1, 1, 3, 4}};
`endif
    tbl[2] = '{{8'd0, 8'd0, 8'd0, 8'd0}, '{0, 0, 2, 0, 1}};
    tbl[3] = '{{8'd0, 8'd9, 8'd0, 8'd0}, '{2, 9, 0, 0, 1}};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_done",    int'(bus.done),    0);
    chk("rst_winner",  int'(bus.winner),  0);
    chk("rst_val",     int'(bus.win_val), 0);
    chk("rst_status",  int'(bus.status),  0);
    chk("rst_iters",   int'(bus.iters),   0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      launch(tbl[i].din);
      chk($sformatf("tbl%0d_done_drop", i), int'(bus.done), 0);
      cyc = 0;
      wait_done(cyc);
      check_res($sformatf("tbl%0d", i), tbl[i].exp, cyc);
    end

    for (int t = 0; t < 24; t++) begin
      int mode;
      int base;
      mode = $urandom_range(0, 3);
      base = $urandom_range(1, 255);
      for (int j = 0; j < N; j++) begin
        case (mode)
          0: v[j*W +: W] = W'($urandom_range(0, 255));
          1: v[j*W +: W] = W'($urandom_range(0, 15));
          2: v[j*W +: W] = W'(base + (($urandom_range(0, 3) == 0) ? 0 : 0) - ((j == N-1 && base > 1) ? $urandom_range(0, 1) : 0));
          default: v[j*W +: W] = ($urandom_range(0, 1) == 0) ? '0 : W'($urandom_range(0, 255));
        endcase
      end
      launch(v);
      cyc = 0;
      wait_done(cyc);
      check_res($sformatf("rnd%0d", t), model(v), cyc);
    end

    // start pulsed while a run is in progress must not disturb it
    launch(tbl[0].din);
    cyc = 0;
    @(posedge clk); #1; cyc++;
    @(negedge clk);
    bus.din   = tbl[3].din;
    bus.start = 1'b1;
    @(posedge clk); #1; cyc++;
    bus.start = 1'b0;
    wait_done(cyc);
    check_res("midstart", tbl[0].exp, cyc);

    // reset in the middle of a run clears outputs; start under reset is ignored
    launch(tbl[1].din);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_done",   int'(bus.done),    0);
    chk("midrst_winner", int'(bus.winner),  0);
    chk("midrst_val",    int'(bus.win_val), 0);
    chk("midrst_status", int'(bus.status),  0);
    chk("midrst_iters",  int'(bus.iters),   0);
    @(negedge clk);
    bus.din   = tbl[3].din;
    bus.start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    bus.start = 1'b0;
    rst       = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_start_ignored_done",   int'(bus.done),   0);
    chk("rst_start_ignored_winner", int'(bus.winner), 0);

    launch(tbl[3].din);
    cyc = 0;
    wait_done(cyc);
    check_res("recover", tbl[3].exp, cyc);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/maxnet_param.md
# maxnet_param

Parametrised MaxNet winner-take-all engine: loads N unsigned activations in one cycle and iterates lateral inhibition, a_j ← max(0, a_j − ε·Σ_{k≠j} a_k) with ε = 2^−EPS_SHIFT, one update per clock. It stops when at most one neuron stays non-zero or the vector stalls, then reports the winner index, the winner's final value, a status code and the iteration count. It generalises the fixed-size maxnet (clk/rst/start/done/result) to configurable channel count, data width and inhibition strength, and adds tie/stall resolution plus an optional iteration cap.

## Interface
- N, 4 — neuron count, ≥2
- W, 8 — activation width, unsigned
- EPS_SHIFT, 2 — ε = 2^−EPS_SHIFT; the integrator must keep ε < 1/(N−1)
- MAX_ITER, 64 — iteration cap, used only with MAXNET_TIMEOUT_EN
- IDXW = clog2(N), derived
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a run; sampled in IDLE and DONE only
- din  in  N*W  activations; neuron j = din[j*W +: W]
- done  out  1  level; high while in DONE
- winner  out  IDXW  winning neuron index
- win_val  out  W  winner's final activation
- status  out  2  00 unique, 01 tie/stall, 10 all-zero, 11 timeout
- iters  out  8  updates applied; saturates at 255

## Operation
- States: IDLE, RUN, DONE. Reset value: IDLE; all outputs 0; activation registers 0.
- IDLE/DONE + start: load din into a[], clear the iteration counter, clear done, go to RUN. In DONE, outputs hold until that edge.
- RUN, evaluated in priority order on the current a[]:
  1. nz(a)=0: DONE, status 10, winner 0, win_val 0.
  2. nz(a)=1: DONE, status 00, winner = the non-zero index, win_val = its value.
  3. With MAXNET_TIMEOUT_EN and iters = MAX_ITER: DONE, status 11, winner = lowest index holding max(a).
  4. Otherwise compute next[]. If nz(next)=0 or next = a: DONE, status 01, winner = lowest index holding max(a); a[] is not updated.
  5. Otherwise a ← next and iters increments, saturating at 255. Stay in RUN.
- Arithmetic:
  - S = Σa over W+IDXW bits.
  - inh_j = (S − a_j) >> EPS_SHIFT, logical shift.
  - next_j = a_j − inh_j if a_j > inh_j, else 0. No wrap-around.
- win_val = a[winner] at the DONE transition.
- start in RUN is ignored.
- rst overrides everything, including mid-run: next edge returns to IDLE with all outputs 0. start is ignored while rst is high.

## Timing
- The edge sampling start is edge 0. RUN evaluates at edges 1, 2, …
- For a run applying k updates, done rises after edge k+1 and stays high until the next start edge or rst.
- Outputs are registered and change only at the DONE transition.
- Worst case is unbounded without the cap; the stall check guarantees termination.

## Configuration
- MAXNET_TIMEOUT_EN defined:
  - Rule 3 is active and status 11 is reachable.
  - Requires 1 ≤ MAX_ITER ≤ 255.
- MAXNET_TIMEOUT_EN undefined:
  - Rule 3 and its comparator are removed.
  - MAX_ITER is ignored and status 11 never occurs.

## Test plan
- Default parameters, din (n0..n3) = 10,20,30,40: vector goes (0,0,13,25) → (0,0,7,22) → (0,0,2,21) → (0,0,0,21). Required: done after edge 5, winner 3, win_val 21, status 00, iters 4.
- din = 50,50,50,50: vector goes 13s → 4s → 1s, then stall. Required: status 01, winner 0, win_val 1, iters 3.
- din = 0,0,0,0: done after edge 1, status 10, winner 0, win_val 0, iters 0. Also din = 0,0,9,0: done after edge 1, status 00, winner 2, win_val 9.
- With MAXNET_TIMEOUT_EN, MAX_ITER = 2, din = 10,20,30,40: done after edge 3, status 11, winner 3, win_val 22, iters 2.
- Control checks:
  - Pulse start mid-RUN: run unaffected.
  - Assert rst mid-RUN: next edge done = 0, outputs 0, state IDLE.
  - Assert start in DONE with new din: done drops after that edge and the new result is correct.
